// File: rtl/align_shifter_pipe.sv
// align_shifter_pipe
// ------------------
// Three-stage mantissa alignment / normalisation shifter for the FP ALU.
//   stage 1 (decode): |BY| magnitude, direction, saturation detect
//   stage 2 (coarse): shift by MAG rounded down to a multiple of 2^FINE_BITS
//   stage 3 (fine)  : shift by the low FINE_BITS of MAG, drive outputs
// Bits shifted out are OR-ed into STICKY (right shifts) or OVF (left shifts).
// Shifts are logical; vacated positions fill with zero.
//
// Ports:
//   CLK, RST              clock (rising edge), synchronous active-high reset
//   IN_VALID / IN_READY   input handshake; IN_READY = !OUT_VALID || OUT_READY
//   IN  [WIDTH-1:0]       mantissa
//   BY  [SHW-1:0]         signed two's-complement shift amount
//   MODE                  0: always right by |BY|; 1: BY>=0 right, BY<0 left
//   OUT_VALID / OUT_READY output handshake
//   OUT [WIDTH-1:0]       shifted mantissa
//   STICKY                OR of bits lost on a right shift (0 on left shifts)
//   OVF                   OR of bits lost on a left shift (0 on right shifts)
//
// The three stages advance or stall together, so a single enable (advance)
// gates every register in the pipe.
module align_shifter_pipe #(
    parameter int WIDTH = 24,
    parameter int SHW   = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] IN,
    input  logic [SHW-1:0]   BY,
    input  logic             MODE,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT,
    output logic             STICKY,
    output logic             OVF
);

    // Fine stage covers ceil(log2(WIDTH)/2) low bits of the magnitude;
    // the coarse stage handles everything above.
    localparam int LOGW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int FINE_BITS = (LOGW + 1) / 2;

    localparam logic [SHW-1:0]   FINE_MASK = SHW'((1 << FINE_BITS) - 1);
    localparam logic [SHW-1:0]   ONE_SHW   = SHW'(1);
    localparam logic [WIDTH-1:0] ALL_ONES  = '1;

    // ------------------------------------------------------------------
    // Handshake / valid chain
    // ------------------------------------------------------------------
    logic [2:0] valid_q;
    logic       advance;

    assign advance   = !valid_q[2] || OUT_READY;
    assign IN_READY  = advance;
    assign OUT_VALID = valid_q[2];

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
        end else if (advance) begin
            valid_q[0] <= IN_VALID;
            for (int i = 1; i < 3; i++) begin
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: decode
    // ------------------------------------------------------------------
    logic [SHW-1:0]   mag_d;
    logic             dir_d;     // 1 = left
    logic             sat_d;

    logic [WIDTH-1:0] s1_data_q;
    logic [SHW-1:0]   s1_mag_q;
    logic             s1_dir_q;
    logic             s1_sat_q;

    always_comb begin
        // Unsigned SHW-bit magnitude: the most negative BY maps to
        // 2^(SHW-1) without wrapping.
        mag_d = BY[SHW-1] ? (~BY + ONE_SHW) : BY;
        dir_d = MODE & BY[SHW-1];
        sat_d = (32'(mag_d) >= 32'(WIDTH));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_data_q <= '0;
            s1_mag_q  <= '0;
            s1_dir_q  <= 1'b0;
            s1_sat_q  <= 1'b0;
        end else if (advance && IN_VALID) begin
            s1_data_q <= IN;
            s1_mag_q  <= mag_d;
            s1_dir_q  <= dir_d;
            s1_sat_q  <= sat_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: coarse shift
    // ------------------------------------------------------------------
    logic [SHW-1:0]       coarse_amt;
    logic [WIDTH-1:0]     s2_data_d;
    logic                 s2_flag_d;
    logic [FINE_BITS-1:0] s2_fine_d;

    logic [WIDTH-1:0]     s2_data_q;
    logic                 s2_flag_q;
    logic [FINE_BITS-1:0] s2_fine_q;
    logic                 s2_dir_q;

    always_comb begin
        coarse_amt = s1_mag_q & ~FINE_MASK;
        s2_data_d  = '0;
        s2_flag_d  = 1'b0;
        s2_fine_d  = '0;
        if (s1_sat_q) begin
            // Everything falls off the end; fine stage then shifts by zero.
            s2_data_d = '0;
            s2_flag_d = |s1_data_q;
        end else if (s1_dir_q) begin
            s2_data_d = s1_data_q << coarse_amt;
            s2_flag_d = |(s1_data_q & ~(ALL_ONES >> coarse_amt));
            s2_fine_d = FINE_BITS'(s1_mag_q & FINE_MASK);
        end else begin
            s2_data_d = s1_data_q >> coarse_amt;
            s2_flag_d = |(s1_data_q & ~(ALL_ONES << coarse_amt));
            s2_fine_d = FINE_BITS'(s1_mag_q & FINE_MASK);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            s2_data_q <= '0;
            s2_flag_q <= 1'b0;
            s2_fine_q <= '0;
            s2_dir_q  <= 1'b0;
        end else if (advance && valid_q[0]) begin
            s2_data_q <= s2_data_d;
            s2_flag_q <= s2_flag_d;
            s2_fine_q <= s2_fine_d;
            s2_dir_q  <= s1_dir_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: fine shift and output registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_data_d;
    logic             out_flag_d;

    logic [WIDTH-1:0] out_data_q;
    logic             sticky_q;
    logic             ovf_q;

    always_comb begin
        out_data_d = '0;
        out_flag_d = s2_flag_q;
        if (s2_dir_q) begin
            out_data_d = s2_data_q << s2_fine_q;
            out_flag_d = s2_flag_q | (|(s2_data_q & ~(ALL_ONES >> s2_fine_q)));
        end else begin
            out_data_d = s2_data_q >> s2_fine_q;
            out_flag_d = s2_flag_q | (|(s2_data_q & ~(ALL_ONES << s2_fine_q)));
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_data_q <= '0;
            sticky_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (advance && valid_q[1]) begin
            out_data_q <= out_data_d;
            // Only the flag matching the shift direction can be set.
            sticky_q   <= out_flag_d & ~s2_dir_q;
            ovf_q      <= out_flag_d & s2_dir_q;
        end
    end

    assign OUT    = out_data_q;
    assign STICKY = sticky_q;
    assign OVF    = ovf_q;

endmodule

// File: tb/tb_align_shifter_pipe.sv
// Directed testbench for align_shifter_pipe (WIDTH=24, SHW=8).
module tb_align_shifter_pipe;

    localparam int WIDTH = 24;
    localparam int SHW   = 8;

    logic             CLK = 1'b0;
    logic             RST;
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] IN;
    logic [SHW-1:0]   BY;
    logic             MODE;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT;
    logic             STICKY;
    logic             OVF;

    align_shifter_pipe #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN        (IN),
        .BY        (BY),
        .MODE      (MODE),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT       (OUT),
        .STICKY    (STICKY),
        .OVF       (OVF)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Backpressure stream: stimulus and hand-computed results.
    logic [23:0] bp_in   [6] = '{24'h123456, 24'hABCDEF, 24'h00FF00, 24'hF00000, 24'h000010, 24'h0F0000};
    logic [7:0]  bp_by   [6] = '{8'h01, 8'h08, 8'hF8, 8'hFC, 8'h05, 8'h0C};
    logic        bp_mode [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [23:0] bp_out  [6] = '{24'h091A2B, 24'h00ABCD, 24'hFF0000, 24'h000000, 24'h000000, 24'h0000F0};
    logic        bp_stk  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        bp_ovf  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Single beat through an empty pipe with OUT_READY high.
    task automatic run_one(input string tag, input logic [23:0] din, input logic [7:0] by,
                           input logic mode, input logic [23:0] eout, input logic es, input logic eo);
        int lat;
        bit seen;
        @(negedge CLK);
        IN_VALID  = 1'b1;
        IN        = din;
        BY        = by;
        MODE      = mode;
        OUT_READY = 1'b1;
        #1;
        check({tag, "_in_ready"}, 32'(IN_READY), 32'd1);
        @(negedge CLK);
        IN_VALID = 1'b0;
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 10) begin
            if (OUT_VALID === 1'b1) seen = 1'b1;
            else begin
                @(negedge CLK);
                lat++;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'd3);
        check({tag, "_out"},     32'(OUT), 32'(eout));
        check({tag, "_sticky"},  32'(STICKY), 32'(es));
        check({tag, "_ovf"},     32'(OVF), 32'(eo));
        $display("txn %s in=%h by=%h mode=%0d out=%h sticky=%0d ovf=%0d lat=%0d",
                 tag, din, by, mode, OUT, STICKY, OVF, lat);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  sent;
        int  got;
        int  cyc;
        bit  saw_ready_low;
        bit  held_valid;
        bit  spurious;
        logic [23:0] held_out;
        logic        held_stk;
        logic        held_ovf;

        // ---------------- Reset with IN_VALID high ----------------
        RST       = 1'b1;
        IN_VALID  = 1'b1;
        IN        = 24'hFFFFFF;
        BY        = 8'h01;
        MODE      = 1'b0;
        OUT_READY = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST      = 1'b0;
        IN_VALID = 1'b0;
        #1;
        check("rst_out_valid", 32'(OUT_VALID), 32'd0);
        check("rst_out",       32'(OUT), 32'd0);
        check("rst_sticky",    32'(STICKY), 32'd0);
        check("rst_ovf",       32'(OVF), 32'd0);
        check("rst_in_ready",  32'(IN_READY), 32'd1);
        spurious = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            if (OUT_VALID !== 1'b0) spurious = 1'b1;
        end
        check("rst_no_output", 32'(spurious), 32'd0);
        $display("txn reset_release done");

        // ---------------- Directed single beats ----------------
        run_one("align_r4",     24'h800001, 8'h04, 1'b0, 24'h080000, 1'b1, 1'b0);
        run_one("align_rm4",    24'h800001, 8'hFC, 1'b0, 24'h080000, 1'b1, 1'b0);
        run_one("left_ovf",     24'h400001, 8'hFE, 1'b1, 24'h000004, 1'b0, 1'b1);
        run_one("left_clean",   24'h000003, 8'hFE, 1'b1, 24'h00000C, 1'b0, 1'b0);
        run_one("sat_m128",     24'h000001, 8'h80, 1'b0, 24'h000000, 1'b1, 1'b0);
        run_one("sat_24",       24'hFFFFFF, 8'h18, 1'b0, 24'h000000, 1'b1, 1'b0);
        run_one("by_23",        24'h800000, 8'h17, 1'b0, 24'h000001, 1'b0, 1'b0);
        run_one("zero_m0",      24'hA5A5A5, 8'h00, 1'b0, 24'hA5A5A5, 1'b0, 1'b0);
        run_one("zero_m1",      24'h5A5A5A, 8'h00, 1'b1, 24'h5A5A5A, 1'b0, 1'b0);
        run_one("left_sat_24",  24'h000001, 8'hE8, 1'b1, 24'h000000, 1'b0, 1'b1);
        run_one("bidir_right9", 24'h000300, 8'h09, 1'b1, 24'h000001, 1'b1, 1'b0);
        run_one("left_m128_z",  24'h000000, 8'h80, 1'b1, 24'h000000, 1'b0, 1'b0);

        // ---------------- Backpressure stream ----------------
        sent = 0; got = 0; cyc = 0;
        saw_ready_low = 1'b0;
        held_valid    = 1'b0;
        held_out = '0; held_stk = 1'b0; held_ovf = 1'b0;
        while (got < 6 && cyc < 40) begin
            @(negedge CLK);
            OUT_READY = !(cyc >= 4 && cyc <= 8);
            if (sent < 6) begin
                IN_VALID = 1'b1;
                IN       = bp_in[sent];
                BY       = bp_by[sent];
                MODE     = bp_mode[sent];
            end else begin
                IN_VALID = 1'b0;
            end
            #1;
            if (held_valid) begin
                check("bp_hold_valid",  32'(OUT_VALID), 32'd1);
                check("bp_hold_out",    32'(OUT), 32'(held_out));
                check("bp_hold_sticky", 32'(STICKY), 32'(held_stk));
                check("bp_hold_ovf",    32'(OVF), 32'(held_ovf));
            end
            held_valid = 1'b0;
            if (OUT_VALID && !OUT_READY) begin
                held_out   = OUT;
                held_stk   = STICKY;
                held_ovf   = OVF;
                held_valid = 1'b1;
            end
            if (!IN_READY) saw_ready_low = 1'b1;
            if (OUT_VALID && OUT_READY) begin
                check($sformatf("bp%0d_out", got),    32'(OUT), 32'(bp_out[got]));
                check($sformatf("bp%0d_sticky", got), 32'(STICKY), 32'(bp_stk[got]));
                check($sformatf("bp%0d_ovf", got),    32'(OVF), 32'(bp_ovf[got]));
                $display("txn bp%0d out=%h sticky=%0d ovf=%0d cycle=%0d", got, OUT, STICKY, OVF, cyc);
                got++;
            end
            if (IN_VALID && IN_READY) sent++;
            cyc++;
        end
        IN_VALID = 1'b0;
        check("bp_received", 32'(got), 32'd6);
        check("bp_sent", 32'(sent), 32'd6);
        check("bp_ready_dropped", 32'(saw_ready_low), 32'd1);
        spurious = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            #1;
            if (OUT_VALID !== 1'b0) spurious = 1'b1;
        end
        check("bp_no_extra", 32'(spurious), 32'd0);

        // ---------------- Reset mid-flight ----------------
        @(negedge CLK);
        OUT_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            IN_VALID = 1'b1;
            IN       = 24'h111111 << i;
            BY       = 8'h01;
            MODE     = 1'b0;
            @(negedge CLK);
        end
        #1;
        check("mf_first_emerging", 32'(OUT_VALID), 32'd1);
        RST       = 1'b1;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        @(negedge CLK);
        RST       = 1'b0;
        OUT_READY = 1'b1;
        #1;
        check("mf_out_valid_cleared", 32'(OUT_VALID), 32'd0);
        spurious = 1'b0;
        repeat (6) begin
            @(negedge CLK);
            #1;
            if (OUT_VALID !== 1'b0) spurious = 1'b1;
        end
        check("mf_none_emerge", 32'(spurious), 32'd0);
        $display("txn midflight_reset done");
        run_one("mf_after", 24'h00F000, 8'h04, 1'b0, 24'h000F00, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
